// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, sequencer state encoding, request
// record and small op-classification helpers. Used by the ALU, the decoder and
// the ALU sequencer.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OpAnd     = 4'h0;
  localparam alu_op_t OpOra     = 4'h1;
  localparam alu_op_t OpEor     = 4'h2;
  localparam alu_op_t OpAdc     = 4'h3;
  localparam alu_op_t OpSbc     = 4'h4;
  localparam alu_op_t OpAsl     = 4'h5;
  localparam alu_op_t OpLsr     = 4'h6;
  localparam alu_op_t OpRol     = 4'h7;
  localparam alu_op_t OpRor     = 4'h8;
  localparam alu_op_t OpCmp     = 4'h9;
  localparam alu_op_t OpBit     = 4'hA;
  localparam alu_op_t OpInc     = 4'hB;
  localparam alu_op_t OpDec     = 4'hC;
  localparam alu_op_t OpBcd2Bin = 4'hD;
  localparam alu_op_t OpBin2Bcd = 4'hE;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StD2b,
    StCompute,
    StWaitPsr,
    StB2d,
    StWrite
  } seq_state_e;

  // Where a finished operation's result goes.
  typedef enum logic [1:0] {
    DstAcc,
    DstMem,
    DstFlags
  } res_dst_e;

  typedef struct packed {
    alu_op_t    op;
    logic [7:0] operand;
    logic [7:0] acc;
    logic       carry;
    logic       decimal;
  } alu_req_t;

  // 0x0D/0x0E are internal BCD conversion steps and 0x0F is unassigned; none of
  // them may be requested directly by the decoder.
  function automatic logic op_is_illegal(alu_op_t op);
    return op >= OpBcd2Bin;
  endfunction

  function automatic logic op_has_decimal_mode(alu_op_t op);
    return (op == OpAdc) || (op == OpSbc);
  endfunction

  function automatic res_dst_e op_dest(alu_op_t op);
    res_dst_e dst;
    case (op)
      OpAsl, OpLsr, OpRol, OpRor, OpInc, OpDec: dst = DstMem;
      OpCmp, OpBit:                             dst = DstFlags;
      default:                                  dst = DstAcc;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one operation request from the decoder, walks the ALU
// through load / optional BCD->binary / compute / flag handshake / optional
// binary->BCD, and emits one result record to the register file / bus unit.
//
// Ports
//   fclk, resb                     clock, asynchronous active-high reset
//   req_*                          valid/ready request from the decoder
//   alu_db_in .. alu_operation_select   drive into the ALU
//   alu_db_out, alu_accumulator_out,
//   alu_psr_update_request, alu_nvzc    results from the ALU
//   alu_ack_update_request          one-cycle acknowledge of a flag update
//   res_*                           result record, res_valid marks the single
//                                   cycle in which it is meaningful
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 8
) (
  input  logic       fclk,
  input  logic       resb,

  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_operand,
  input  logic [7:0] req_acc,
  input  logic       req_carry,
  input  logic       req_decimal,

  output logic [7:0] alu_db_in,
  output logic [7:0] alu_acc_in,
  output logic       alu_carry,
  output logic       alu_decimal,
  output logic       alu_instruction_decode_in,
  output logic       alu_acc_to_alu_xfer,
  output logic       alu_compute_step,
  output logic [3:0] alu_operation_select,

  input  logic [7:0] alu_db_out,
  input  logic [7:0] alu_accumulator_out,
  input  logic       alu_psr_update_request,
  input  logic [3:0] alu_nvzc,
  output logic       alu_ack_update_request,

  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_to_mem,
  output logic [3:0] res_nvzc,
  output logic       res_flags_we,
  output logic       res_err
);

  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  seq_state_e       state_q, state_d;
  alu_req_t         req_q;
  logic             dec_path_q;  // decimal ADC/SBC: wrap COMPUTE in BCD conversions
  logic             err_q;
  logic             flags_q;     // flags latched from the ALU for this operation
  logic [3:0]       nvzc_q;
  logic [WdogW-1:0] wdog_q;

  logic     accept;
  logic     psr_take;
  logic     wdog_expire;
  res_dst_e dst;

  assign accept = req_valid && req_ready;
  assign dst    = op_dest(req_q.op);

  // Next-state and strobe decode.
  always_comb begin
    state_d                   = state_q;
    req_ready                 = 1'b0;
    alu_instruction_decode_in = 1'b0;
    alu_acc_to_alu_xfer       = 1'b0;
    alu_compute_step          = 1'b0;
    alu_operation_select      = 4'h0;
    alu_ack_update_request    = 1'b0;
    res_valid                 = 1'b0;
    psr_take                  = 1'b0;
    wdog_expire               = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Illegal ops spend this cycle here with the ALU left untouched.
        if (err_q) begin
          state_d = StWrite;
        end else begin
          alu_instruction_decode_in = 1'b1;
          alu_acc_to_alu_xfer       = 1'b1;
          state_d                   = dec_path_q ? StD2b : StCompute;
        end
      end
      StD2b: begin
        alu_operation_select = OpBcd2Bin;
        alu_compute_step     = 1'b1;
        state_d              = StCompute;
      end
      StCompute: begin
        alu_operation_select = req_q.op;
        alu_compute_step     = 1'b1;
        state_d              = StWaitPsr;
      end
      StWaitPsr: begin
        if (alu_psr_update_request) begin
          psr_take               = 1'b1;
          alu_ack_update_request = 1'b1;
          state_d                = dec_path_q ? StB2d : StWrite;
        end else if (wdog_q == WdogLast) begin
          wdog_expire = 1'b1;
          state_d     = StWrite;
        end
      end
      StB2d: begin
        alu_operation_select = OpBin2Bcd;
        alu_compute_step     = 1'b1;
        state_d              = StWrite;
      end
      StWrite: begin
        res_valid = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge fclk or posedge resb) begin
    if (resb) begin
      state_q    <= StIdle;
      req_q      <= '0;
      dec_path_q <= 1'b0;
      err_q      <= 1'b0;
      flags_q    <= 1'b0;
      nvzc_q     <= 4'h0;
      wdog_q     <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        req_q      <= '{op: req_op, operand: req_operand, acc: req_acc,
                        carry: req_carry, decimal: req_decimal};
        dec_path_q <= req_decimal && op_has_decimal_mode(req_op);
        err_q      <= op_is_illegal(req_op);
        flags_q    <= 1'b0;
      end

      if (wdog_expire) begin
        err_q <= 1'b1;
      end

      if (psr_take) begin
        nvzc_q  <= alu_nvzc;
        flags_q <= 1'b1;
      end

      // Held at zero outside WAIT_PSR so every entry starts a fresh count.
      if (state_q != StWaitPsr) begin
        wdog_q <= '0;
      end else if (!alu_psr_update_request) begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  // Captured operands are driven continuously; the ALU only samples them on
  // its load strobes, and they stay stable from LOAD through WRITE.
  assign alu_db_in   = req_q.operand;
  assign alu_acc_in  = req_q.acc;
  assign alu_carry   = req_q.carry;
  assign alu_decimal = req_q.decimal;

  assign res_nvzc = nvzc_q;

  // Result record is zero outside the WRITE cycle.
  always_comb begin
    res_data     = 8'h00;
    res_to_mem   = 1'b0;
    res_flags_we = 1'b0;
    res_err      = 1'b0;
    if (state_q == StWrite) begin
      res_err      = err_q;
      res_flags_we = flags_q && !err_q;
      case (dst)
        DstMem: begin
          res_to_mem = 1'b1;
          res_data   = alu_db_out;
        end
        DstFlags: res_data = req_q.acc;
        default:  res_data = alu_accumulator_out;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int unsigned WDOG = 8;
  localparam logic [4:0] TL = 5'h10;  // trace code: load strobes
  localparam logic [4:0] TA = 5'h11;  // trace code: flag acknowledge

  logic       fclk = 1'b0;
  logic       resb = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0;
  logic [7:0] req_operand = '0;
  logic [7:0] req_acc = '0;
  logic       req_carry = 1'b0;
  logic       req_decimal = 1'b0;
  logic [7:0] alu_db_in;
  logic [7:0] alu_acc_in;
  logic       alu_carry;
  logic       alu_decimal;
  logic       alu_instruction_decode_in;
  logic       alu_acc_to_alu_xfer;
  logic       alu_compute_step;
  logic [3:0] alu_operation_select;
  logic [7:0] alu_db_out = '0;
  logic [7:0] alu_accumulator_out = '0;
  logic       alu_psr_update_request = 1'b0;
  logic [3:0] alu_nvzc = '0;
  logic       alu_ack_update_request;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_to_mem;
  logic [3:0] res_nvzc;
  logic       res_flags_we;
  logic       res_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 fclk = ~fclk;

  alu_sequencer #(.WDOG_CYCLES(WDOG)) dut (
    .fclk                     (fclk),
    .resb                     (resb),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_op                   (req_op),
    .req_operand              (req_operand),
    .req_acc                  (req_acc),
    .req_carry                (req_carry),
    .req_decimal              (req_decimal),
    .alu_db_in                (alu_db_in),
    .alu_acc_in               (alu_acc_in),
    .alu_carry                (alu_carry),
    .alu_decimal              (alu_decimal),
    .alu_instruction_decode_in(alu_instruction_decode_in),
    .alu_acc_to_alu_xfer      (alu_acc_to_alu_xfer),
    .alu_compute_step         (alu_compute_step),
    .alu_operation_select     (alu_operation_select),
    .alu_db_out               (alu_db_out),
    .alu_accumulator_out      (alu_accumulator_out),
    .alu_psr_update_request   (alu_psr_update_request),
    .alu_nvzc                 (alu_nvzc),
    .alu_ack_update_request   (alu_ack_update_request),
    .res_valid                (res_valid),
    .res_data                 (res_data),
    .res_to_mem               (res_to_mem),
    .res_nvzc                 (res_nvzc),
    .res_flags_we             (res_flags_we),
    .res_err                  (res_err)
  );

  // delay: cycles after the matching compute step before the bench ALU raises
  // its flag request (255 = never). lat: cycle of res_valid, acceptance = 0.
  typedef struct {
    logic [3:0]  op;
    logic [7:0]  operand;
    logic [7:0]  acc;
    logic        carry;
    logic        dec;
    int          delay;
    logic [3:0]  nvzc;
    logic [7:0]  db_out;
    logic [7:0]  acc_out;
    int          lat;
    logic [7:0]  data;
    logic        mem;
    logic        fwe;
    logic        err;
    logic [63:0] trace;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] operand,
                              input logic [7:0] acc, input logic carry, input logic dec,
                              input int delay, input logic [3:0] nvzc,
                              input logic [7:0] db_out, input logic [7:0] acc_out,
                              input int lat, input logic [7:0] data, input logic mem,
                              input logic fwe, input logic err, input logic [63:0] trace);
    vec_t v;
    v.op = op; v.operand = operand; v.acc = acc; v.carry = carry; v.dec = dec;
    v.delay = delay; v.nvzc = nvzc; v.db_out = db_out; v.acc_out = acc_out;
    v.lat = lat; v.data = data; v.mem = mem; v.fwe = fwe; v.err = err; v.trace = trace;
    return v;
  endfunction

  // Entered just after a falling edge; returns just after a falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    int          valid_cyc;
    int          comp_cyc;
    logic        acked;
    logic        drv_ok;
    logic        excl_ok;
    logic [63:0] trace;
    logic [7:0]  got_data;
    logic        got_mem, got_fwe, got_err;
    logic [3:0]  got_nvzc;
    string       tag;
    tag = $sformatf("v%0d", idx);

    req_op = v.op; req_operand = v.operand; req_acc = v.acc;
    req_carry = v.carry; req_decimal = v.dec; req_valid = 1'b1;
    alu_db_out = v.db_out; alu_accumulator_out = v.acc_out; alu_nvzc = v.nvzc;
    #1;
    check({tag, " ready_at_accept"}, 64'(req_ready), 64'd1);

    valid_cyc = -1; comp_cyc = -1; acked = 1'b0; drv_ok = 1'b1; excl_ok = 1'b1;
    trace = '0; got_data = '0; got_mem = 0; got_fwe = 0; got_err = 0; got_nvzc = '0;
    for (int cyc = 1; cyc <= 40 && valid_cyc < 0; cyc++) begin
      @(negedge fclk);
      if (cyc == 1) begin
        // Scramble request fields so only captured values can reach the ALU.
        req_valid = 1'b0;
        req_op = 4'h5; req_operand = 8'hA5; req_acc = 8'h5A;
        req_carry = ~v.carry; req_decimal = ~v.dec;
      end
      alu_psr_update_request = (comp_cyc >= 0) && (cyc >= comp_cyc + v.delay) && !acked;
      #1;
      if (int'(alu_instruction_decode_in) + int'(alu_compute_step) > 1) excl_ok = 1'b0;
      if (alu_carry !== v.carry || alu_decimal !== v.dec) drv_ok = 1'b0;
      if (alu_instruction_decode_in) begin
        trace = (trace << 5) | 64'(TL);
        if (!alu_acc_to_alu_xfer || alu_db_in !== v.operand || alu_acc_in !== v.acc)
          drv_ok = 1'b0;
      end else if (alu_acc_to_alu_xfer) begin
        drv_ok = 1'b0;
      end
      if (alu_compute_step) begin
        trace = (trace << 5) | 64'(alu_operation_select);
        if (alu_operation_select == v.op) comp_cyc = cyc;
      end
      if (alu_ack_update_request) begin
        trace = (trace << 5) | 64'(TA);
        if (!alu_psr_update_request) drv_ok = 1'b0;
        acked = 1'b1;
      end
      if (res_valid) begin
        valid_cyc = cyc;
        got_data = res_data; got_mem = res_to_mem; got_fwe = res_flags_we;
        got_err = res_err; got_nvzc = res_nvzc;
      end
    end
    alu_psr_update_request = 1'b0;

    check({tag, " latency"}, 64'(valid_cyc), 64'(v.lat));
    check({tag, " res_data"}, 64'(got_data), 64'(v.data));
    check({tag, " res_to_mem"}, 64'(got_mem), 64'(v.mem));
    check({tag, " res_flags_we"}, 64'(got_fwe), 64'(v.fwe));
    check({tag, " res_err"}, 64'(got_err), 64'(v.err));
    if (v.fwe) check({tag, " res_nvzc"}, 64'(got_nvzc), 64'(v.nvzc));
    check({tag, " strobe_trace"}, trace, v.trace);
    check({tag, " alu_drive"}, 64'(drv_ok), 64'd1);
    check({tag, " strobe_exclusive"}, 64'(excl_ok), 64'd1);

    @(negedge fclk);
    #1;
    check({tag, " ready_after_write"}, 64'({req_ready, res_valid}), 64'b10);
  endtask

  initial begin
    int n_valid;

    vecs[0]  = mk(4'h3, 8'h05, 8'h03, 0, 0, 1, 4'h0, 8'h00, 8'h08, 4, 8'h08, 0, 1, 0,
                  64'({TL, 5'h03, TA}));
    vecs[1]  = mk(4'h3, 8'h15, 8'h27, 0, 1, 1, 4'h0, 8'h00, 8'h42, 6, 8'h42, 0, 1, 0,
                  64'({TL, 5'h0D, 5'h03, TA, 5'h0E}));
    vecs[2]  = mk(4'h5, 8'h81, 8'h10, 0, 0, 1, 4'h1, 8'h02, 8'h55, 4, 8'h02, 1, 1, 0,
                  64'({TL, 5'h05, TA}));
    vecs[3]  = mk(4'h9, 8'h40, 8'h33, 1, 0, 1, 4'h3, 8'h77, 8'h99, 4, 8'h33, 0, 1, 0,
                  64'({TL, 5'h09, TA}));
    vecs[4]  = mk(4'h0, 8'h0F, 8'hFF, 0, 1, 1, 4'h0, 8'h00, 8'h0F, 4, 8'h0F, 0, 1, 0,
                  64'({TL, 5'h00, TA}));
    vecs[5]  = mk(4'h4, 8'h19, 8'h50, 1, 1, 3, 4'h1, 8'h00, 8'h31, 8, 8'h31, 0, 1, 0,
                  64'({TL, 5'h0D, 5'h04, TA, 5'h0E}));
    vecs[6]  = mk(4'hB, 8'h0F, 8'h00, 0, 0, 1, 4'h0, 8'h10, 8'hEE, 4, 8'h10, 1, 1, 0,
                  64'({TL, 5'h0B, TA}));
    vecs[7]  = mk(4'h1, 8'h01, 8'h02, 1, 0, 255, 4'h0, 8'h00, 8'h5A, WDOG + 3, 8'h5A, 0, 0, 1,
                  64'({TL, 5'h01}));
    vecs[8]  = mk(4'hE, 8'h12, 8'h34, 1, 1, 1, 4'h0, 8'h00, 8'hC3, 2, 8'hC3, 0, 0, 1, 64'd0);
    vecs[9]  = mk(4'hF, 8'h12, 8'h34, 0, 0, 1, 4'h0, 8'h66, 8'h3C, 2, 8'h3C, 0, 0, 1, 64'd0);
    vecs[10] = mk(4'h2, 8'h11, 8'h22, 0, 0, WDOG + 1, 4'h0, 8'h00, 8'h33, WDOG + 3, 8'h33,
                  0, 0, 1, 64'({TL, 5'h02}));
    vecs[11] = mk(4'h2, 8'h11, 8'h22, 0, 0, WDOG, 4'hA, 8'h00, 8'h33, WDOG + 3, 8'h33,
                  0, 1, 0, 64'({TL, 5'h02, TA}));

    // Reset state.
    #2;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset outputs", 64'({res_valid, res_data, res_to_mem, res_nvzc, res_flags_we,
                                res_err, alu_ack_update_request, alu_compute_step,
                                alu_instruction_decode_in, alu_acc_to_alu_xfer,
                                alu_operation_select, alu_db_in, alu_acc_in,
                                alu_carry, alu_decimal}), 64'd0);
    @(negedge fclk);
    @(negedge fclk);
    resb = 1'b0;
    @(negedge fclk);
    #1;

    // Table vectors, issued back to back.
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset pulsed while waiting for the flag request.
    req_op = 4'h1; req_operand = 8'h01; req_acc = 8'h02; req_carry = 1'b1;
    req_decimal = 1'b1; req_valid = 1'b1;
    @(negedge fclk);  // LOAD
    req_valid = 1'b0;
    @(negedge fclk);  // COMPUTE
    @(negedge fclk);  // WAIT_PSR
    #1;
    alu_psr_update_request = 1'b1;
    resb = 1'b1;
    #1;
    check("rst_mid ready", 64'(req_ready), 64'd1);
    check("rst_mid outputs", 64'({res_valid, res_nvzc, res_err, res_flags_we,
                                  alu_ack_update_request, alu_compute_step,
                                  alu_carry, alu_decimal}), 64'd0);
    #2;
    resb = 1'b0;
    alu_psr_update_request = 1'b0;
    n_valid = 0;
    for (int c = 0; c < WDOG + 6; c++) begin
      @(negedge fclk);
      #1;
      if (res_valid) n_valid++;
    end
    check("rst_mid no_res_valid", 64'(n_valid), 64'd0);
    check("rst_mid idle_ready", 64'(req_ready), 64'd1);
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 8, meaning the cycle limit in WAIT_PSR before abort.
REQ-002 SHALL have port fclk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port resb, input, 1 bit: asynchronous, active-high reset (1 = reset asserted).
REQ-004 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_op (in, 4), req_operand (in, 8), req_acc (in, 8), req_carry (in, 1), req_decimal (in, 1): the operation request from the decoder.
REQ-005 SHALL have ports alu_db_in (out, 8), alu_acc_in (out, 8), alu_carry (out, 1), alu_decimal (out, 1), alu_instruction_decode_in (out, 1), alu_acc_to_alu_xfer (out, 1), alu_compute_step (out, 1), alu_operation_select (out, 4): ALU drive.
REQ-006 SHALL have ports alu_db_out (in, 8), alu_accumulator_out (in, 8), alu_psr_update_request (in, 1), alu_nvzc (in, 4): ALU results; alu_ack_update_request (out, 1).
REQ-007 SHALL have ports res_valid (out, 1), res_data (out, 8), res_to_mem (out, 1), res_nvzc (out, 4), res_flags_we (out, 1), res_err (out, 1): result to register file / bus unit.

Function
REQ-008 SHALL implement states IDLE, LOAD, D2B, COMPUTE, WAIT_PSR, B2D, WRITE.
REQ-009 IDLE: req_ready=1; on req_valid&req_ready, SHALL capture all req_* fields and go to LOAD; req_ready=0 in every other state.
REQ-010 req_op 0x0D, 0x0E, 0x0F SHALL be accepted, then go directly to WRITE with res_err=1, res_flags_we=0.
REQ-011 LOAD: SHALL assert alu_instruction_decode_in and alu_acc_to_alu_xfer for exactly one cycle, with alu_db_in=captured operand, alu_acc_in=captured acc.
REQ-012 After LOAD: captured decimal=1 and op in {0x03 ADC, 0x04 SBC} -> D2B; else -> COMPUTE.
REQ-013 D2B: alu_operation_select=0x0D, alu_compute_step=1 for one cycle, then COMPUTE.
REQ-014 COMPUTE: alu_operation_select=captured op, alu_compute_step=1 for one cycle, then WAIT_PSR.
REQ-015 alu_carry and alu_decimal SHALL hold captured values from LOAD through WRITE.
REQ-016 WAIT_PSR: on alu_psr_update_request=1, SHALL latch alu_nvzc into res_nvzc, assert alu_ack_update_request for exactly that one cycle, then go to B2D (decimal ADC/SBC) or WRITE.
REQ-017 WAIT_PSR watchdog: counter cleared on entry; if WDOG_CYCLES cycles elapse without request, SHALL go to WRITE with res_err=1, res_flags_we=0.
REQ-018 B2D: alu_operation_select=0x0E, alu_compute_step=1 for one cycle, then WRITE.
REQ-019 WRITE: res_valid=1 for exactly one cycle, then IDLE; res_flags_we=1 iff flags latched and no error.
REQ-020 Destination: ops 0x05-0x08, 0x0B, 0x0C -> res_to_mem=1, res_data=alu_db_out; ops 0x09, 0x0A -> res_to_mem=0, res_data=captured acc (flags only); all others -> res_to_mem=0, res_data=alu_accumulator_out.
REQ-021 Latency: non-decimal op with immediate psr request SHALL give res_valid 4 cycles after acceptance; decimal ADC/SBC 6 cycles.
REQ-022 All ALU strobes SHALL be 0 outside their named states; at most one of alu_compute_step/load strobes active per cycle.
REQ-023 Back-to-back: req_ready SHALL return to 1 the cycle after WRITE; no request is lost or duplicated.

Reset
REQ-024 resb=1 SHALL asynchronously force IDLE and all outputs to 0 except req_ready=1, including mid-operation; no res_valid SHALL be emitted for an aborted operation.
REQ-025 Captured fields, res_nvzc and watchdog counter SHALL reset to 0.

Structure
REQ-026 Op-code constants (AND..BIN2BCD, 0x00-0x0E) and the state enum SHALL live in shared package alu_pkg, also used by the ALU and decoder.
REQ-027 No sub-module; watchdog counter and FSM are inline.

Verification
REQ-028 ADC op=0x03, operand=0x05, acc=0x03, carry=0, decimal=0, ALU raises psr 1 cycle after COMPUTE with nvzc=0000 -> res_valid 4 cycles after accept, res_data=0x08, res_to_mem=0, res_flags_we=1.
REQ-029 ADC decimal=1, operand=0x15, acc=0x27 -> strobe order LOAD, op 0x0D, op 0x03, ack, op 0x0E; res_valid at cycle 6, res_data=0x42.
REQ-030 ASL op=0x05, operand=0x81, carry=0 -> res_to_mem=1, res_data=0x02, res_nvzc=0001.
REQ-031 COMPUTE with psr request held 0 -> res_valid exactly WDOG_CYCLES+3 cycles after accept, res_err=1, res_flags_we=0; next req_ready=1.
REQ-032 resb pulsed during WAIT_PSR -> immediate IDLE, req_ready=1, no res_valid, no ack; following request completes normally.
REQ-033 req_op=0x0E -> res_valid 2 cycles after accept with res_err=1, no ALU strobes.
